iq_symb_pingpong: RTL and testbench

IQ_SYMB_PINGPONG -- requirements
Module: iq_symb_pingpong

---
 rtl/pusch_pkg.sv | 19 +
 rtl/iq_symb_pingpong_if.sv | 38 +++
 rtl/iq_sdp_ram.sv | 21 ++
 rtl/iq_symb_pingpong.sv | 156 +++++++++++++++
 tb/tb_iq_symb_pingpong.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pusch_pkg.sv
// rtl/pusch_pkg.sv - shared PUSCH constants, symbol header and read-FSM state types
package pusch_pkg;
  localparam int ANT     = 4;
  localparam int PRB_NUM = 132;
  localparam int RE_NUM  = PRB_NUM * 12;

  typedef struct packed {
    logic [3:0] pkg_type;
    logic       cell_idx;
    logic [6:0] slot_idx;
    logic [3:0] symb_idx;
  } symb_hdr_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_RELEASE
  } rd_state_t;
endpackage

// File: rtl/iq_symb_pingpong_if.sv
// rtl/iq_symb_pingpong_if.sv - IQ write stream and buffered read stream bundle
interface iq_symb_pingpong_if #(
  parameter int ANT = 4
);
  logic [ANT*32-1:0] iq_data;
  logic [10:0]       iq_addr;
  logic              iq_vld;
  logic              iq_last;
  logic [6:0]        slot_idx;
  logic [3:0]        symb_idx;
  logic              cell_idx;
  logic [3:0]        pkg_type;

  logic [ANT*32-1:0] rd_data;
  logic [10:0]       rd_addr;
  logic              rd_vld;
  logic              rd_last;
  logic              rd_ready;
  logic [6:0]        rd_slot_idx;
  logic [3:0]        rd_symb_idx;
  logic              rd_cell_idx;
  logic [3:0]        rd_pkg_type;
  logic              drop;
  logic              addr_err;
  logic [1:0]        bank_full;

  modport master (
    output iq_data, iq_addr, iq_vld, iq_last, slot_idx, symb_idx, cell_idx, pkg_type, rd_ready,
    input  rd_data, rd_addr, rd_vld, rd_last, rd_slot_idx, rd_symb_idx, rd_cell_idx, rd_pkg_type,
    input  drop, addr_err, bank_full
  );

  modport slave (
    input  iq_data, iq_addr, iq_vld, iq_last, slot_idx, symb_idx, cell_idx, pkg_type, rd_ready,
    output rd_data, rd_addr, rd_vld, rd_last, rd_slot_idx, rd_symb_idx, rd_cell_idx, rd_pkg_type,
    output drop, addr_err, bank_full
  );
endinterface

// File: rtl/iq_sdp_ram.sv
// rtl/iq_sdp_ram.sv - simple dual-port RAM, registered read with one-cycle latency
module iq_sdp_ram #(
  parameter int W  = 128,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [1<<AW];

  // rdata holds its value when re is low; the read side relies on this as a pipeline stage
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/iq_symb_pingpong.sv
// rtl/iq_symb_pingpong.sv - two-bank symbol ping-pong buffer, RE-indexed writes, in-order stream read
module iq_symb_pingpong #(
  parameter int ANT    = pusch_pkg::ANT,
  parameter int RE_NUM = pusch_pkg::RE_NUM
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ANT*32-1:0] i_iq_data,
  input  logic [10:0]       i_iq_addr,
  input  logic              i_iq_vld,
  input  logic              i_iq_last,
  input  logic [6:0]        i_slot_idx,
  input  logic [3:0]        i_symb_idx,
  input  logic              i_cell_idx,
  input  logic [3:0]        i_pkg_type,
  output logic [ANT*32-1:0] o_rd_data,
  output logic [10:0]       o_rd_addr,
  output logic              o_rd_vld,
  output logic              o_rd_last,
  input  logic              i_rd_ready,
  output logic [6:0]        o_slot_idx,
  output logic [3:0]        o_symb_idx,
  output logic              o_cell_idx,
  output logic [3:0]        o_pkg_type,
  output logic              o_drop,
  output logic              o_addr_err,
  output logic [1:0]        o_bank_full
);
  import pusch_pkg::*;

  localparam int          DW      = ANT * 32;
  localparam logic [10:0] RE_END  = 11'(RE_NUM);
  localparam logic [10:0] RE_LAST = 11'(RE_NUM - 1);

  logic      wr_sel, rd_sel, dropping;
  symb_hdr_t in_hdr, out_hdr;
  symb_hdr_t hdr [2];
  logic      start, addr_ok, discard, ram_we, set_full, last_xfer;
  logic [1:0] set_vec, clr_vec;

  assign in_hdr   = {i_pkg_type, i_cell_idx, i_slot_idx, i_symb_idx};
  assign start    = i_iq_vld && (i_iq_addr == 11'd0);
  assign addr_ok  = i_iq_addr < RE_END;
  // a symbol that opened on a full bank stays discarded until its last RE
  assign discard  = start ? o_bank_full[wr_sel] : dropping;
  assign ram_we   = i_iq_vld && !discard && addr_ok;
  assign set_full = i_iq_vld && i_iq_last && !discard;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_sel     <= 1'b0;
      dropping   <= 1'b0;
      o_drop     <= 1'b0;
      o_addr_err <= 1'b0;
      hdr[0]     <= '0;
      hdr[1]     <= '0;
    end else begin
      o_drop     <= start && o_bank_full[wr_sel];
      o_addr_err <= i_iq_vld && !addr_ok;
      if (i_iq_vld) dropping <= discard && !i_iq_last;
      if (start && !discard) hdr[wr_sel] <= in_hdr;
      if (set_full) wr_sel <= ~wr_sel;
    end
  end

  assign set_vec = set_full  ? (2'b01 << wr_sel) : 2'b00;
  assign clr_vec = last_xfer ? (2'b01 << rd_sel) : 2'b00;

  always_ff @(posedge i_clk) begin
    if (i_reset) o_bank_full <= 2'b00;
    else         o_bank_full <= (o_bank_full | set_vec) & ~clr_vec;
  end

  rd_state_t   state, state_nxt;
  logic [10:0] rd_cnt;
  logic        issue, out_vld, xfer, p_out;
  logic        p_vld, p_last, sk_vld, sk_last;
  logic [10:0] p_addr, sk_addr;
  logic [DW-1:0] ram_rdata, sk_data;

  iq_sdp_ram #(.W(DW), .AW(12)) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .waddr ({wr_sel, i_iq_addr}),
    .wdata (i_iq_data),
    .re    (issue),
    .raddr ({rd_sel, rd_cnt}),
    .rdata (ram_rdata)
  );

  // RAM output register is skid entry 0, sk_* is entry 1; issue never waits on i_rd_ready
  assign issue     = (state == RD_READ) && (rd_cnt != RE_END) && !sk_vld;
  assign out_vld   = sk_vld || p_vld;
  assign xfer      = out_vld && i_rd_ready;
  assign p_out     = xfer && !sk_vld;
  assign last_xfer = xfer && o_rd_last;

  assign o_rd_vld  = out_vld;
  assign o_rd_data = sk_vld ? sk_data : (p_vld ? ram_rdata : '0);
  assign o_rd_addr = sk_vld ? sk_addr : (p_vld ? p_addr : 11'd0);
  assign o_rd_last = sk_vld ? sk_last : (p_vld && p_last);

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE:    if (o_bank_full[rd_sel]) state_nxt = RD_READ;
      RD_READ:    if (last_xfer) state_nxt = RD_RELEASE;
      RD_RELEASE: state_nxt = RD_IDLE;
      default:    state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= RD_IDLE;
      rd_sel  <= 1'b0;
      rd_cnt  <= 11'd0;
      out_hdr <= '0;
      p_vld   <= 1'b0;
      p_addr  <= 11'd0;
      p_last  <= 1'b0;
      sk_vld  <= 1'b0;
      sk_addr <= 11'd0;
      sk_last <= 1'b0;
      sk_data <= '0;
    end else begin
      state <= state_nxt;
      if (state != RD_READ) rd_cnt <= 11'd0;
      else if (issue)       rd_cnt <= rd_cnt + 11'd1;
      if (state == RD_IDLE && o_bank_full[rd_sel]) out_hdr <= hdr[rd_sel];
      if (last_xfer) rd_sel <= ~rd_sel;

      if (issue) begin
        p_vld  <= 1'b1;
        p_addr <= rd_cnt;
        p_last <= (rd_cnt == RE_LAST);
      end else if (p_out) begin
        p_vld <= 1'b0;
      end

      if (sk_vld) begin
        if (xfer) sk_vld <= 1'b0;
      end else if (issue && p_vld && !p_out) begin
        sk_vld  <= 1'b1;
        sk_data <= ram_rdata;
        sk_addr <= p_addr;
        sk_last <= p_last;
      end
    end
  end

  assign o_slot_idx = out_hdr.slot_idx;
  assign o_symb_idx = out_hdr.symb_idx;
  assign o_cell_idx = out_hdr.cell_idx;
  assign o_pkg_type = out_hdr.pkg_type;
endmodule

// File: tb/tb_iq_symb_pingpong.sv
// tb/tb_iq_symb_pingpong.sv - directed scoreboard bench for the symbol ping-pong buffer
module tb_iq_symb_pingpong;
  import pusch_pkg::*;

  localparam int NA  = 4;
  localparam int NRE = 1584;
  localparam int DW  = NA * 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [10:0]   addr;
    logic          last;
    logic [6:0]    slot;
    logic [3:0]    symb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iq_symb_pingpong_if #(.ANT(NA)) bus ();

  iq_symb_pingpong #(.ANT(NA), .RE_NUM(NRE)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_iq_data   (bus.iq_data),
    .i_iq_addr   (bus.iq_addr),
    .i_iq_vld    (bus.iq_vld),
    .i_iq_last   (bus.iq_last),
    .i_slot_idx  (bus.slot_idx),
    .i_symb_idx  (bus.symb_idx),
    .i_cell_idx  (bus.cell_idx),
    .i_pkg_type  (bus.pkg_type),
    .o_rd_data   (bus.rd_data),
    .o_rd_addr   (bus.rd_addr),
    .o_rd_vld    (bus.rd_vld),
    .o_rd_last   (bus.rd_last),
    .i_rd_ready  (bus.rd_ready),
    .o_slot_idx  (bus.rd_slot_idx),
    .o_symb_idx  (bus.rd_symb_idx),
    .o_cell_idx  (bus.rd_cell_idx),
    .o_pkg_type  (bus.rd_pkg_type),
    .o_drop      (bus.drop),
    .o_addr_err  (bus.addr_err),
    .o_bank_full (bus.bank_full)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;

  function automatic logic [DW-1:0] pat(input int id, input int a);
    logic [DW-1:0] d;
    for (int k = 0; k < NA; k++) d[k*32 +: 32] = {4'(k), 1'b0, 11'(a), 16'(id)};
    return d;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // one clock: score a transfer at the negedge, then drive ready for the next cycle
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.rd_vld && bus.rd_ready) begin
      check("queue_nonempty", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rd_beat", 256'({bus.rd_data, bus.rd_addr, bus.rd_last, bus.rd_slot_idx, bus.rd_symb_idx}), 256'(e));
      end
    end
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.rd_ready = 1'b0;
      1:       bus.rd_ready = 1'b1;
      2:       bus.rd_ready = 1'($urandom_range(0, 1));
      default: bus.rd_ready = !(bus.rd_vld && bus.rd_last);
    endcase
  endtask

  task automatic write_re(input int id, input int a, input int slot, input int symb);
    bus.iq_data  = pat(id, a);
    bus.iq_addr  = 11'(a);
    bus.iq_vld   = 1'b1;
    bus.iq_last  = (a == NRE - 1);
    bus.slot_idx = 7'(slot);
    bus.symb_idx = 4'(symb);
    tick();
    bus.iq_vld  = 1'b0;
    bus.iq_last = 1'b0;
  endtask

  task automatic write_symbol(input int id, input int slot, input int symb, input int n,
                              input int exp_drop, input int bad_at);
    int drops = 0;
    int errs  = 0;
    for (int a = 0; a < n; a++) begin
      if (a == bad_at) begin
        bus.iq_data = '1;
        bus.iq_addr = 11'd1600;
        bus.iq_vld  = 1'b1;
        bus.iq_last = 1'b0;
        tick();
        errs += int'(bus.addr_err);
      end
      write_re(id, a, slot, symb);
      drops += int'(bus.drop);
      errs  += int'(bus.addr_err);
    end
    check("drop_pulses", 256'(drops), 256'(exp_drop));
    check("addr_err_pulses", 256'(errs), 256'(bad_at >= 0 ? 1 : 0));
  endtask

  task automatic push_symbol(input int id, input int slot, input int symb);
    for (int a = 0; a < NRE; a++) exp_q.push_back({pat(id, a), 11'(a), (a == NRE - 1), 7'(slot), 4'(symb)});
  endtask

  task automatic drain(input string tag, input bit contig);
    int  n = 0;
    int  gaps = 0;
    bit  started = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      if (bus.rd_vld) started = 1;
      else if (started) gaps++;
      tick();
      n++;
    end
    check({tag, "_drained"}, 256'(exp_q.size()), 256'(0));
    if (contig) check({tag, "_gaps"}, 256'(gaps), 256'(0));
  endtask

  initial begin
    int n;
    int vcount;
    bus.iq_data = '0; bus.iq_addr = '0; bus.iq_vld = 1'b0; bus.iq_last = 1'b0;
    bus.slot_idx = '0; bus.symb_idx = '0; bus.cell_idx = 1'b0; bus.pkg_type = '0;
    bus.rd_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_ctrl", 256'({bus.rd_vld, bus.rd_last, bus.bank_full, bus.drop, bus.addr_err, bus.rd_addr,
                             bus.rd_slot_idx, bus.rd_symb_idx, bus.rd_cell_idx, bus.rd_pkg_type}), 256'(0));
    check("reset_data", 256'(bus.rd_data), 256'(0));
    rst = 1'b0;
    tick();

    // single symbol, ready high: latency and contiguous stream
    ready_mode = 1;
    write_symbol(1, 5, 3, NRE, 0, -1);
    push_symbol(1, 5, 3);
    check("t1_full", 256'(bus.bank_full), 256'(2'b01));
    check("t1_lat0", 256'(bus.rd_vld), 256'(0));
    tick();
    check("t1_lat1", 256'(bus.rd_vld), 256'(0));
    tick();
    check("t1_lat2", 256'({bus.rd_vld, bus.rd_addr, bus.rd_slot_idx}), 256'({1'b1, 11'd0, 7'd5}));
    drain("t1", 1);
    check("t1_released", 256'(bus.bank_full), 256'(0));

    // random backpressure
    ready_mode = 2;
    write_symbol(2, 9, 7, NRE, 0, -1);
    push_symbol(2, 9, 7);
    drain("t2", 0);

    // three symbols with output stalled: third is dropped
    ready_mode = 0;
    tick();
    write_symbol(3, 10, 1, NRE, 0, -1);
    push_symbol(3, 10, 1);
    write_symbol(4, 11, 2, NRE, 0, -1);
    push_symbol(4, 11, 2);
    write_symbol(5, 12, 4, NRE, 1, -1);
    check("t3_both_full", 256'(bus.bank_full), 256'(2'b11));
    ready_mode = 1;
    drain("t3", 0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      vcount += int'(bus.rd_vld);
      tick();
    end
    check("t3_no_extra", 256'(vcount), 256'(0));
    check("t3_empty", 256'(bus.bank_full), 256'(0));

    // bank 1 fills on the same edge bank 0 is released
    ready_mode = 0;
    write_symbol(6, 20, 5, NRE, 0, -1);
    push_symbol(6, 20, 5);
    write_symbol(7, 21, 6, NRE - 1, 0, -1);
    ready_mode = 3;
    n = 0;
    while (!(bus.rd_vld && bus.rd_last) && n < 5000) begin
      tick();
      n++;
    end
    check("t4_at_last", 256'({bus.rd_vld, bus.rd_last, bus.bank_full}), 256'({2'b11, 2'b01}));
    ready_mode = 1;
    bus.rd_ready = 1'b1;
    write_re(7, NRE - 1, 21, 6);
    check("t4_swap", 256'(bus.bank_full), 256'(2'b10));
    push_symbol(7, 21, 6);
    drain("t4", 0);

    // out-of-range write mid-symbol
    write_symbol(8, 2, 1, NRE, 0, 5);
    push_symbol(8, 2, 1);
    drain("t5", 1);

    // reset in the middle of a read
    write_symbol(9, 30, 8, NRE, 0, -1);
    push_symbol(9, 30, 8);
    n = 0;
    while (!(bus.rd_vld && bus.rd_addr == 11'd700) && n < 5000) begin
      tick();
      n++;
    end
    check("t6_at_700", 256'({bus.rd_vld, bus.rd_addr}), 256'({1'b1, 11'd700}));
    rst = 1'b1;
    tick();
    check("t6_reset_out", 256'({bus.rd_vld, bus.bank_full}), 256'(0));
    exp_q.delete();
    rst = 1'b0;
    tick();
    write_symbol(10, 40, 9, NRE, 0, -1);
    push_symbol(10, 40, 9);
    drain("t6", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
